ntt_result_serializer: RTL and testbench
========================================

// Module: ntt_result_serializer
// PURPOSE
//  Drain-side counterpart of the NTT processor output. Captures one parallel beat of router output
//  (two 60-bit words + one 9-bit address per core) and emits the words one per cycle on a
//  valid/ready stream, tagged with a global word index. A small beat FIFO absorbs bursts, since the
//  processor has no stall input.
// PARAMETERS
//  LOG_CORE_COUNT  5  log2 of core count; CORES = 1 << LOG_CORE_COUNT
//  LOG_FIFO_DEPTH  2  log2 of beat FIFO depth (default 4 beats)
//  IDX_W (localparam) = 9 + LOG_CORE_COUNT + 1, width of out_index
// PORTS
//  clk           in   1                    single clock, all logic on posedge
//  rst           in   1                    synchronous reset, active-high
//  in_valid      in   1                    beat present on in_data/in_address this cycle
//  in_data       in   [59:0][CORES-1:0][1:0]  per-core word pair, same layout as processor out
//  in_address    in   [8:0][CORES-1:0]     per-core address, same layout as processor address_out
//  out_valid     out  1                    out_data/out_index/out_last valid
//  out_ready     in   1                    downstream accepts word
//  out_data      out  60                   serialized word
//  out_index     out  IDX_W                {address[k], k[LOG_CORE_COUNT-1:0], j}
//  out_last      out  1                    final word of current beat
//  beats_pending out  LOG_FIFO_DEPTH+1     occupancy in beats, including head beat
//  overflow      out  1                    sticky dropped-beat flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: beats_pending=0, out_valid=0, out_last=0, overflow=0, word selector sel=0, FIFO
//    pointers=0. out_data/out_index are don't-care while out_valid=0; bench checks them only when
//    out_valid=1.
//  - Storage: circular buffer of 2^LOG_FIFO_DEPTH beats, each CORES*(2*60+9) bits. wr_ptr/rd_ptr are
//    LOG_FIFO_DEPTH bits and wrap modulo depth. Count is a separate register.
//  - Push: the beat is written at wr_ptr on a cycle with in_valid=1, if count < depth or a pop
//    happens in the same cycle.
//  - Drop: in_valid=1 with count == depth and no pop in that cycle -> beat discarded. FIFO state is
//    unchanged.
//  - out_valid = (count != 0). Latency: beat pushed at cycle t -> out_valid=1 at t+1 if FIFO was
//    empty.
//  - sel counts 0 .. 2*CORES-1 over the head beat: k = sel[LOG_CORE_COUNT:1], j = sel[0].
//    out_data = head.data[k][j]; out_index = {head.address[k], k, j}.
//  - out_last = out_valid && (sel == 2*CORES-1).
//  - Word handshake: out_valid && out_ready -> sel increments. On the out_last handshake sel returns
//    to 0, rd_ptr advances and count decrements. That last handshake is the pop.
//  - Simultaneous push and pop: count unchanged, both pointers advance. When full, the push is
//    accepted.
//  - Stability: while out_valid && !out_ready, out_data, out_index and out_last hold.
//  - out_data and out_index come combinationally from registered storage and sel. No
//    combinational path from out_ready to out_data.
//  - Reset mid-beat: the partially drained beat and all queued beats are discarded; sel=0.
//  - Mid-beat arithmetic: none on data. Index concatenation only, no carries.
// CONFIGURATION
//  NTT_SER_OVERFLOW_EN defined: overflow is set on any drop and held until rst.
//  NTT_SER_OVERFLOW_EN undefined: overflow is tied 0 and no flag register is built. Drop behaviour
//  is identical.
// TESTING (LOG_CORE_COUNT=1, LOG_FIFO_DEPTH=2 unless noted)
//  1. One beat: core0 words {A0,A1}, addr 5; core1 words {B0,B1}, addr 5; out_ready=1.
//     -> idx 20,21,22,23 with data A0,A1,B0,B1 on 4 consecutive cycles starting 1 cycle after
//     push. out_last only on idx 23.
//  2. Backpressure: out_ready toggles 1,0,0,1.
//     -> each word holds while stalled; no repeat or skip; 4 handshakes total.
//  3. Burst: 5 beats on consecutive cycles, out_ready=0.
//     -> beats_pending = 4; 5th beat dropped; overflow=1 with the macro, 0 without.
//     Then drain: 16 words in push order.
//  4. Full + pop: FIFO full; push coincides with the out_last handshake.
//     -> beat accepted, beats_pending stays 4, overflow stays 0.
//  5. Reset mid-beat: rst pulsed after 2 of 4 words.
//     -> next cycle out_valid=0, beats_pending=0, overflow=0. A new beat then starts at its j=0,k=0
//     word.
//  6. LOG_CORE_COUNT=5, addr 511 on core 31 -> out_index 15'h7FFE and 15'h7FFF, the latter with
//     out_last.

Source files
------------

// File: rtl/ntt_result_serializer.sv
// Beat FIFO + word serializer for NTT router output; optional sticky drop
// flag built when NTT_SER_OVERFLOW_EN is defined.
module ntt_result_serializer #(
    parameter  int LOG_CORE_COUNT = 5,
    parameter  int LOG_FIFO_DEPTH = 2,
    localparam int CORES          = 1 << LOG_CORE_COUNT,
    localparam int IDX_W          = 9 + LOG_CORE_COUNT + 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic [59:0][CORES-1:0][1:0]       in_data,
    input  logic [8:0][CORES-1:0]             in_address,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [59:0]                       out_data,
    output logic [IDX_W-1:0]                  out_index,
    output logic                              out_last,
    output logic [LOG_FIFO_DEPTH:0]           beats_pending,
    output logic                              overflow
);

    localparam int DEPTH   = 1 << LOG_FIFO_DEPTH;
    localparam int SEL_W   = LOG_CORE_COUNT + 1;
    localparam int SEL_MAX = 2 * CORES - 1;

    logic [59:0][CORES-1:0][1:0] data_mem [DEPTH];
    logic [8:0][CORES-1:0]       addr_mem [DEPTH];

    logic [LOG_FIFO_DEPTH-1:0]   wr_ptr;
    logic [LOG_FIFO_DEPTH-1:0]   rd_ptr;
    logic [LOG_FIFO_DEPTH:0]     count;
    logic [SEL_W-1:0]            sel;

    logic                        full;
    logic                        handshake;
    logic                        pop;
    logic                        push;
    logic [LOG_CORE_COUNT-1:0]   k;
    logic                        j;
    logic [59:0][CORES-1:0][1:0] head_data;
    logic [8:0][CORES-1:0]       head_addr;
    logic [8:0]                  addr_k;

    assign full      = (count == DEPTH[LOG_FIFO_DEPTH:0]);
    assign out_valid = (count != '0);
    assign out_last  = out_valid && (sel == SEL_MAX[SEL_W-1:0]);
    assign handshake = out_valid && out_ready;
    assign pop       = handshake && out_last;
    // A full FIFO still takes a beat when the head retires this same cycle.
    assign push      = in_valid && (!full || pop);

    assign beats_pending = count;

    assign k = sel[SEL_W-1:1];
    assign j = sel[0];

    assign head_data = data_mem[rd_ptr];
    assign head_addr = addr_mem[rd_ptr];

    // Storage is bit-major, so gather one word / address across bit planes.
    always_comb begin
        out_data = '0;
        addr_k   = '0;
        for (int b = 0; b < 60; b++) begin
            out_data[b] = head_data[b][k][j];
        end
        for (int b = 0; b < 9; b++) begin
            addr_k[b] = head_addr[b][k];
        end
    end

    assign out_index = {addr_k, sel};

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= in_data;
            addr_mem[wr_ptr] <= in_address;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            sel    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                sel    <= '0;
            end else if (handshake) begin
                sel <= sel + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef NTT_SER_OVERFLOW_EN
    logic drop;

    assign drop = in_valid && !push;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_ntt_result_serializer.sv
// Bench for ntt_result_serializer: queue-of-beats reference model with
// randomized words, plus a 32-core instance for index boundary checks.
module tb_ntt_result_serializer;

`ifdef NTT_SER_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    typedef struct packed {
        logic [3:0][59:0] w;
        logic [1:0][8:0]  a;
    } beat_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  in_valid = 1'b0;
    logic [59:0][1:0][1:0] in_data;
    logic [8:0][1:0]       in_address;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [59:0]           out_data;
    logic [10:0]           out_index;
    logic                  out_last;
    logic [2:0]            beats_pending;
    logic                  overflow;

    logic                    w_in_valid = 1'b0;
    logic [59:0][31:0][1:0]  w_in_data;
    logic [8:0][31:0]        w_in_address;
    logic                    w_out_valid;
    logic                    w_out_ready = 1'b0;
    logic [59:0]             w_out_data;
    logic [14:0]             w_out_index;
    logic                    w_out_last;
    logic [2:0]              w_beats_pending;
    logic                    w_overflow;

    beat_t cur;
    beat_t mq[$];
    int    msel;
    bit    movf;
    int    n_chk;
    int    n_pass;

    always #5 clk = ~clk;

    always_comb begin
        in_data    = '0;
        in_address = '0;
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 2; j++) begin
                for (int b = 0; b < 60; b++) begin
                    in_data[b][k][j] = cur.w[2*k+j][b];
                end
            end
            for (int b = 0; b < 9; b++) begin
                in_address[b][k] = cur.a[k][b];
            end
        end
    end

    ntt_result_serializer #(.LOG_CORE_COUNT(1), .LOG_FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_address(in_address), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last),
        .beats_pending(beats_pending), .overflow(overflow)
    );

    ntt_result_serializer #(.LOG_CORE_COUNT(5), .LOG_FIFO_DEPTH(2)) dut_wide (
        .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_data(w_in_data),
        .in_address(w_in_address), .out_valid(w_out_valid),
        .out_ready(w_out_ready), .out_data(w_out_data),
        .out_index(w_out_index), .out_last(w_out_last),
        .beats_pending(w_beats_pending), .overflow(w_overflow)
    );

    function automatic logic [59:0] rand_word();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[59:0];
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        for (int i = 0; i < 4; i++) b.w[i] = rand_word();
        for (int i = 0; i < 2; i++) b.a[i] = 9'($urandom_range(0, 511));
        return b;
    endfunction

    function automatic logic [76:0] obs_vec();
        logic [59:0] d;
        logic [10:0] ix;
        d  = out_valid ? out_data : 60'd0;
        ix = out_valid ? out_index : 11'd0;
        return {out_valid, out_last, overflow, beats_pending, ix, d};
    endfunction

    // Expected stream: head beat's words in order k=0..1, j=0..1.
    function automatic logic [76:0] exp_vec();
        logic [59:0] d;
        logic [10:0] ix;
        logic        v;
        logic        l;
        d  = '0;
        ix = '0;
        l  = 1'b0;
        v  = (mq.size() != 0);
        if (v) begin
            d  = mq[0].w[msel];
            ix = 11'(int'(mq[0].a[msel/2]) * 4 + msel);
            l  = (msel == 3);
        end
        return {v, l, movf, 3'(mq.size()), ix, d};
    endfunction

    task automatic tick();
        bit hs;
        bit pop;
        bit push;
        if (rst) begin
            mq.delete();
            msel = 0;
            movf = 1'b0;
        end else begin
            hs   = (mq.size() != 0) && out_ready;
            pop  = hs && (msel == 3);
            push = in_valid && (mq.size() < 4 || pop);
            if (in_valid && !push) movf = OVF_EN;
            if (pop) begin
                void'(mq.pop_front());
                msel = 0;
            end else if (hs) begin
                msel++;
            end
            if (push) mq.push_back(cur);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_chk++;
        if ({out_valid, out_last, overflow, beats_pending} !== 6'd0) begin
            $display("FAIL reset got v=%b l=%b o=%b p=%0d want all 0",
                     out_valid, out_last, overflow, beats_pending);
        end else n_pass++;
    endtask

    task automatic test_one_beat();
        cur = rand_beat();
        cur.a[0] = 9'd5;
        cur.a[1] = 9'd5;
        out_ready = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (obs_vec() !== exp_vec() || out_index !== 11'(20 + i)) begin
                $display("FAIL one_beat[%0d] got %h want %h idx %0d",
                         i, obs_vec(), exp_vec(), 20 + i);
            end else n_pass++;
            tick();
        end
        n_chk++;
        if (out_valid !== 1'b0) begin
            $display("FAIL one_beat_empty got %b want 0", out_valid);
        end else n_pass++;
    endtask

    task automatic test_backpressure();
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int hs;
        int c;
        hs = 0;
        c = 0;
        cur = rand_beat();
        out_ready = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        while (mq.size() != 0 && c < 20) begin
            out_ready = pat[c % 4];
            n_chk++;
            if (obs_vec() !== exp_vec()) begin
                $display("FAIL backpressure[%0d] got %h want %h",
                         c, obs_vec(), exp_vec());
            end else n_pass++;
            if (out_valid && out_ready) hs++;
            tick();
            c++;
        end
        n_chk++;
        if (hs !== 4 || out_valid !== 1'b0) begin
            $display("FAIL backpressure_count got %0d want 4", hs);
        end else n_pass++;
    endtask

    task automatic test_burst();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cur = rand_beat();
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        n_chk++;
        if (beats_pending !== 3'd4 || overflow !== OVF_EN) begin
            $display("FAIL burst_full got p=%0d o=%b want p=4 o=%b",
                     beats_pending, overflow, OVF_EN);
        end else n_pass++;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_chk++;
            if (obs_vec() !== exp_vec()) begin
                $display("FAIL burst_drain[%0d] got %h want %h",
                         i, obs_vec(), exp_vec());
            end else n_pass++;
            tick();
        end
        n_chk++;
        if (out_valid !== 1'b0) begin
            $display("FAIL burst_empty got %b want 0", out_valid);
        end else n_pass++;
    endtask

    task automatic test_full_pop();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cur = rand_beat();
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                cur = rand_beat();
                in_valid = 1'b1;
            end
            n_chk++;
            if (obs_vec() !== exp_vec()) begin
                $display("FAIL full_pop_head[%0d] got %h want %h",
                         i, obs_vec(), exp_vec());
            end else n_pass++;
            tick();
        end
        in_valid = 1'b0;
        n_chk++;
        if (beats_pending !== 3'd4 || overflow !== 1'b0) begin
            $display("FAIL full_pop got p=%0d o=%b want p=4 o=0",
                     beats_pending, overflow);
        end else n_pass++;
        for (int i = 0; i < 16; i++) begin
            n_chk++;
            if (obs_vec() !== exp_vec()) begin
                $display("FAIL full_pop_drain[%0d] got %h want %h",
                         i, obs_vec(), exp_vec());
            end else n_pass++;
            tick();
        end
    endtask

    task automatic test_reset_mid();
        cur = rand_beat();
        out_ready = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_chk++;
            if (obs_vec() !== exp_vec()) begin
                $display("FAIL reset_mid_pre[%0d] got %h want %h",
                         i, obs_vec(), exp_vec());
            end else n_pass++;
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_chk++;
        if ({out_valid, overflow, beats_pending} !== 5'd0) begin
            $display("FAIL reset_mid got v=%b o=%b p=%0d want 0 0 0",
                     out_valid, overflow, beats_pending);
        end else n_pass++;
        cur = rand_beat();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_chk++;
        if (out_index !== 11'(int'(cur.a[0]) * 4) || out_data !== cur.w[0]) begin
            $display("FAIL reset_mid_restart got i=%0d d=%h want i=%0d d=%h",
                     out_index, out_data, int'(cur.a[0]) * 4, cur.w[0]);
        end else n_pass++;
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cur = rand_beat();
            in_valid = ($urandom_range(0, 99) < 40);
            out_ready = ($urandom_range(0, 99) < 70);
            n_chk++;
            if (obs_vec() !== exp_vec()) begin
                $display("FAIL random[%0d] got %h want %h",
                         i, obs_vec(), exp_vec());
            end else n_pass++;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_wide_index();
        logic [59:0] ww [64];
        logic [8:0]  wa [32];
        logic [75:0] got;
        logic [75:0] want;
        for (int i = 0; i < 64; i++) ww[i] = rand_word();
        for (int k = 0; k < 32; k++) wa[k] = 9'($urandom_range(0, 511));
        wa[31] = 9'd511;
        for (int k = 0; k < 32; k++) begin
            for (int j = 0; j < 2; j++) begin
                for (int b = 0; b < 60; b++) w_in_data[b][k][j] = ww[2*k+j][b];
            end
            for (int b = 0; b < 9; b++) w_in_address[b][k] = wa[k][b];
        end
        w_out_ready = 1'b1;
        w_in_valid = 1'b1;
        @(posedge clk);
        #1;
        w_in_valid = 1'b0;
        for (int i = 0; i < 64; i++) begin
            got  = {w_out_valid, w_out_last, w_out_index, w_out_data};
            want = {1'b1, 1'(i == 63), 15'(int'(wa[i/2]) * 64 + i), ww[i]};
            n_chk++;
            if (got !== want) begin
                $display("FAIL wide[%0d] got %h want %h", i, got, want);
            end else n_pass++;
            if (i >= 62) begin
                n_chk++;
                if (w_out_index !== ((i == 62) ? 15'h7FFE : 15'h7FFF)) begin
                    $display("FAIL wide_top[%0d] got %h want %h", i,
                             w_out_index, (i == 62) ? 15'h7FFE : 15'h7FFF);
                end else n_pass++;
            end
            @(posedge clk);
            #1;
        end
        n_chk++;
        if (w_out_valid !== 1'b0) begin
            $display("FAIL wide_empty got %b want 0", w_out_valid);
        end else n_pass++;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        msel = 0;
        movf = 1'b0;
        cur = '0;
        w_in_data = '0;
        w_in_address = '0;
        test_reset();
        test_one_beat();
        test_backpressure();
        test_burst();
        test_full_pop();
        test_reset_mid();
        test_random();
        test_wide_index();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
